// File: rtl/div_restoring_48x24_if.sv
// Handshake/data bundle for the 48/24 restoring divider.
// The requester drives start/a/b; the divider returns q/r/busy/ready/overflow.
interface div_restoring_48x24_if #(
    parameter int WIDTH = 24
);
    logic                 start;
    logic [2*WIDTH-1:0]   a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     r;
    logic                 busy;
    logic                 ready;
    logic                 overflow;

    modport master (
        output start, a, b,
        input  q, r, busy, ready, overflow
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, ready, overflow
    );
endinterface

// File: rtl/div_restoring_48x24.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional macro DIV_OVERFLOW_CHECK_EN adds an early-out when the quotient cannot fit (a_hi >= b, including b=0).
module div_restoring_48x24 #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    div_restoring_48x24_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [CNT_W-1:0]   count;
    logic               ovf_pend_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   r_r;
    logic               busy_r;
    logic               ready_r;
    logic               ovf_r;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   a_hi_s;
    logic               ovf_hit_s;

    // Trial subtraction for the current iteration and the optional overflow comparator.
    always_comb begin
        a_hi_s    = bus.a[2*WIDTH-1:WIDTH];
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
`ifdef DIV_OVERFLOW_CHECK_EN
        ovf_hit_s = (a_hi_s >= bus.b);
`else
        ovf_hit_s = 1'b0;
`endif
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem_r      <= '0;
            quo_r      <= '0;
            dvs_r      <= '0;
            count      <= '0;
            ovf_pend_r <= 1'b0;
            q_r        <= '0;
            r_r        <= '0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the ready pulse is deliberately refused.
                    if (bus.start && !ready_r) begin
                        dvs_r  <= bus.b;
                        rem_r  <= a_hi_s;
                        count  <= '0;
                        busy_r <= 1'b1;
                        ovf_r  <= 1'b0;
                        if (ovf_hit_s) begin
                            quo_r      <= '1;
                            ovf_pend_r <= 1'b1;
                            state      <= DONE;
                        end else begin
                            quo_r      <= bus.a[WIDTH-1:0];
                            ovf_pend_r <= 1'b0;
                            state      <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // The remainder's top bit is always zero, so only WIDTH bits are stored.
                    if (trial_s[WIDTH] == 1'b0) begin
                        rem_r <= trial_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= shifted_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CNT_W'(1);
                    if (count == LAST_CNT) begin
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    q_r     <= quo_r;
                    r_r     <= rem_r;
                    ovf_r   <= ovf_pend_r;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.q        = q_r;
    assign bus.r        = r_r;
    assign bus.busy     = busy_r;
    assign bus.ready    = ready_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_div_restoring_48x24.sv
// Directed scoreboard bench for div_restoring_48x24: latency, handshake, arithmetic results and reset.
module tb_div_restoring_48x24;
    localparam int W = 24;

    logic clk;
    logic rst;
    int   vectors;
    int   fails;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        bit           chk;
        int           lat;
    } exp_t;

    exp_t sb[$];

    div_restoring_48x24_if #(.WIDTH(W)) bus ();

    div_restoring_48x24 #(.WIDTH(W), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one accepted edge, then confirm busy rose.
    task automatic begin_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 48'(bus.busy), 48'd1);
    endtask

    task automatic launch(input logic [2*W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic eovf, input bit chk, input int lat);
        exp_t e;
        e.q = eq; e.r = er; e.ovf = eovf; e.chk = chk; e.lat = lat;
        sb.push_back(e);
        begin_op(a, b);
    endtask

    // Wait (bounded) for ready; edges_done edges have already elapsed since the accept edge.
    task automatic finish_op(input string tag, input int edges_done);
        int   k;
        int   nb;
        bit   seen;
        exp_t e;
        k = edges_done; nb = 0; seen = 1'b0;
        while (k < 200) begin
            tick();
            k++;
            if (bus.ready) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) nb++;
        end
        check({tag, "_ready_seen"}, 48'(seen), 48'd1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 48'd1, 48'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, 48'(k), 48'(e.lat));
            check({tag, "_busy_cycles"}, 48'(nb), 48'(e.lat - 1 - edges_done));
            check({tag, "_busy_at_ready"}, 48'(bus.busy), 48'd0);
            check({tag, "_overflow"}, 48'(bus.overflow), 48'(e.ovf));
            if (e.chk) begin
                check({tag, "_q"}, 48'(bus.q), 48'(e.q));
                check({tag, "_r"}, 48'(bus.r), 48'(e.r));
            end
        end
    endtask

    initial begin
        logic [2*W-1:0] ra;
        logic [W-1:0]   rb;
        logic [W-1:0]   rhi;
        logic [2*W-1:0] rq;
        logic [2*W-1:0] rr;
        int             rdy_seen;

        vectors = 0; fails = 0;
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        tick(); tick();
        check("reset_q", 48'(bus.q), 48'd0);
        check("reset_r", 48'(bus.r), 48'd0);
        check("reset_busy", 48'(bus.busy), 48'd0);
        check("reset_ready", 48'(bus.ready), 48'd0);
        check("reset_overflow", 48'(bus.overflow), 48'd0);
        rst = 1'b0;
        tick();

        // 100 / 7
        launch(48'd100, 24'd7, 24'd14, 24'd2, 1'b0, 1'b1, W + 1);
        finish_op("div100_7", 0);
        tick();
        check("ready_one_cycle", 48'(bus.ready), 48'd0);
        tick(); tick(); tick();
        check("q_hold_idle", 48'(bus.q), 48'd14);
        check("r_hold_idle", 48'(bus.r), 48'd2);

        // 0xFFFFFF squared / 0xFFFFFF
        launch(48'hFFFFFE000001, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 1'b0, 1'b1, W + 1);
        finish_op("square", 0);
        tick();

        // 0xFFFFFF / 0x10, then start in ready cycle (refused) and in the next cycle (accepted)
        launch(48'h000000FFFFFF, 24'h000010, 24'h0FFFFF, 24'hF, 1'b0, 1'b1, W + 1);
        finish_op("div_by_16", 0);
        bus.a = 48'd9; bus.b = 24'd3; bus.start = 1'b1;
        tick();
        check("start_in_ready_refused", 48'(bus.busy), 48'd0);
        launch(48'd5, 24'd5, 24'd1, 24'd0, 1'b0, 1'b1, W + 1);
        finish_op("back_to_back", 0);
        tick();

        // Start while busy is ignored and operands are not re-captured
        launch(48'd100, 24'd7, 24'd14, 24'd2, 1'b0, 1'b1, W + 1);
        tick(); tick();
        bus.a = 48'd9; bus.b = 24'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.a = 48'hABCDEF123456; bus.b = 24'h000001;
        finish_op("start_while_busy", 3);
        tick();

        // Scoreboard-modelled vectors with a_hi < b
        for (int i = 0; i < 3; i++) begin
            rb  = {1'b1, 23'($urandom_range(0, 32'h7FFFFF))};
            rhi = 24'($urandom) % rb;
            ra  = {rhi, 24'($urandom)};
            rq  = ra / {24'd0, rb};
            rr  = ra % {24'd0, rb};
            launch(ra, rb, rq[W-1:0], rr[W-1:0], 1'b0, 1'b1, W + 1);
            finish_op("random", 0);
            tick();
        end

        // Divide by zero: early-out with the check enabled, full-length run otherwise
`ifdef DIV_OVERFLOW_CHECK_EN
        launch(48'h000123000000, 24'h0, 24'hFFFFFF, 24'h000123, 1'b1, 1'b1, 1);
`else
        launch(48'h000123000000, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0, W + 1);
`endif
        finish_op("div_by_zero", 0);
        tick();

        // Reset ten cycles into an operation abandons it
        begin_op(48'd100, 24'd7);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst_q", 48'(bus.q), 48'd0);
        check("midrst_r", 48'(bus.r), 48'd0);
        check("midrst_busy", 48'(bus.busy), 48'd0);
        check("midrst_ready", 48'(bus.ready), 48'd0);
        check("midrst_overflow", 48'(bus.overflow), 48'd0);
        rst = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ready) rdy_seen++;
        end
        check("midrst_no_ready", 48'(rdy_seen), 48'd0);
        check("scoreboard_drained", 48'(sb.size()), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/div_restoring_48x24.md
Name: div_restoring_48x24

Overview:
- Sequential radix-2 restoring divider. It divides a 48-bit dividend by a 24-bit divisor and returns a 24-bit quotient and a 24-bit remainder.
- It is the inverse of the 24x24 product path. The intended use is mantissa divide and product-normalisation checks in the FP datapath.
- It retires one quotient bit per clock and uses a start/busy/ready handshake.

Parameters:
- WIDTH, 24: divisor, quotient and remainder width. The dividend is 2*WIDTH bits.
- CNT_W, 5: iteration counter width. Must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request. Sampled only while busy=0.
- a  input  2*WIDTH  dividend. Captured on an accepted start.
- b  input  WIDTH  divisor. Captured on an accepted start.
- q  output  WIDTH  quotient. Valid from ready until the next accepted start.
- r  output  WIDTH  remainder. Valid from ready until the next accepted start.
- busy  output  1  high while an operation is in progress.
- ready  output  1  one-cycle pulse when q and r become valid.
- overflow  output  1  quotient does not fit (a[2W-1:W] >= b, which includes b=0). Valid with ready.

Behaviour:
- Reset: rst=1 at a clock edge forces the following, regardless of state:
  - state=IDLE;
  - q=0, r=0, busy=0, ready=0, overflow=0, count=0.
  - Reset mid-operation abandons the operation. No ready pulse is produced for it.
- States:
  - IDLE, RUN, DONE.
  - DONE lasts exactly one cycle.
- IDLE:
  - On start=1, capture b into the divisor register.
  - Load the partial remainder R (WIDTH+1 bits) with {1'b0, a[2W-1:W]}.
  - Load the quotient shift register Q with a[W-1:0].
  - Set count=0 and busy=1, then go to RUN.
  - start=0 keeps IDLE, and q/r hold their previous values.
- RUN, per cycle:
  - T = {R[W-1:0], Q[W-1]} - {1'b0, b}, computed as a (W+1)-bit subtraction.
  - If T[W]=0: R <= T and Q <= {Q[W-2:0], 1'b1}.
  - Otherwise: R <= {R[W-1:0], Q[W-1]} and Q <= {Q[W-2:0], 1'b0}.
  - count increments each cycle. After the iteration with count=WIDTH-1, go to DONE.
- DONE:
  - q is driven from Q and r from R[W-1:0]; ready=1 for this cycle; busy drops to 0.
  - Then go to IDLE.
- Latency:
  - An accepted start at edge N gives busy=1 from edge N.
  - ready=1 in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles from start to ready.
  - Back-to-back: a start asserted in the ready cycle is not accepted. The earliest accepted start is the cycle after ready.
- start while busy=1 (RUN or DONE) is ignored, and the captured operands are unaffected.
- a and b may change freely after acceptance; only the captured copies are used.
- Results are exact (a = q*b + r, r < b) whenever a[2W-1:W] < b.
- q and r hold their values indefinitely in IDLE.

Optional Feature:
- Macro: DIV_OVERFLOW_CHECK_EN.
- Defined:
  - On an accepted start, compare a[2W-1:W] >= b, which also covers b=0.
  - If the comparison is true, skip RUN: go IDLE -> DONE directly, with busy=1 for one cycle.
  - In DONE, overflow=1, q={WIDTH{1'b1}}, r=a[2W-1:W], and ready pulses. Total start-to-ready latency is 2 cycles.
  - overflow=0 on all non-overflowing operations.
- Not defined:
  - No comparator is built and overflow is tied to 0.
  - Overflowing inputs run the normal WIDTH-iteration sequence. The resulting q/r are deterministic but carry no arithmetic guarantee; the bench checks timing only for these cases.

Test Plan:
- a=100, b=7, one start pulse -> busy high for WIDTH+1 cycles; ready pulse at WIDTH+2; q=14, r=2, overflow=0.
- a=0xFFFFFE000001 (0xFFFFFF squared), b=0xFFFFFF -> q=0xFFFFFF, r=0.
- a=0x000000FFFFFF, b=0x000010 -> q=0x0FFFFF, r=0xF. Then start again the cycle after ready with a=5, b=5 -> q=1, r=0.
- Start with a=100, b=7; pulse start again 3 cycles later with a=9, b=3 -> second start ignored; q=14, r=2. Then rst=1 at cycle 10 of a new operation -> all outputs 0 next cycle and no ready pulse.
- With DIV_OVERFLOW_CHECK_EN: b=0, a=0x000123000000 -> ready 2 cycles after start, overflow=1, q=0xFFFFFF, r=0x000123.
- Without DIV_OVERFLOW_CHECK_EN: same inputs -> overflow=0 and ready at WIDTH+2.
